// File: rtl/conv_window_buffer.sv
// conv_window_buffer: two-row line buffer plus 3x3 sliding window feeding the convolution core.
// Only full, in-row windows (row>=2, col>=2) are emitted; output regs update only on those.
module conv_window_buffer #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int COL_W      = 5,
    parameter int ROW_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vbit_i,
    input  logic [7:0]  pixel_i,
    output logic [23:0] data_line0,
    output logic [23:0] data_line1,
    output logic [23:0] data_line2,
    output logic        vbit_o,
    output logic        frame_done
);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0] lineB0 [IMG_WIDTH];
    logic [7:0] lineB1 [IMG_WIDTH];
    logic [23:0] win0, win1, win2, nextWin0, nextWin1, nextWin2;
    logic colLast, rowLast, inRegion;

    always_comb begin
        colLast  = col == COL_W'(IMG_WIDTH - 1);
        rowLast  = row == ROW_W'(IMG_HEIGHT - 1);
        inRegion = row >= ROW_W'(2) && col >= COL_W'(2);
        nextWin0 = {lineB0[col], win0[23:8]};
        nextWin1 = {lineB1[col], win1[23:8]};
        nextWin2 = {pixel_i, win2[23:8]};
    end

    // Line buffers are never cleared; rows 0..1 of each frame overwrite them before any read is emitted.
    always_ff @(posedge clk) begin
        if (vbit_i) begin
            lineB0[col] <= lineB1[col];
            lineB1[col] <= pixel_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win0       <= '0;
            win1       <= '0;
            win2       <= '0;
            data_line0 <= '0;
            data_line1 <= '0;
            data_line2 <= '0;
            vbit_o     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vbit_o     <= vbit_i && inRegion;
            frame_done <= vbit_i && inRegion && colLast && rowLast;
            if (vbit_i) begin
                win0 <= nextWin0;
                win1 <= nextWin1;
                win2 <= nextWin2;
                col  <= colLast ? '0 : col + 1'b1;
                row  <= colLast ? (rowLast ? '0 : row + 1'b1) : row;
                if (inRegion) begin
                    data_line0 <= nextWin0;
                    data_line1 <= nextWin1;
                    data_line2 <= nextWin2;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: random and directed streams into a 4x4 and a 28x28 instance,
// each checked every cycle against an image-array model of the valid-region windows.
module tb_conv_window_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tbR [2];
    logic        tbV [2];
    logic [7:0]  tbP [2];
    logic        vbo [2];
    logic        fdo [2];
    logic [23:0] dl [2][3];

    conv_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .COL_W(2), .ROW_W(2)) dutS (
        .clk(clk), .rst(tbR[0]), .vbit_i(tbV[0]), .pixel_i(tbP[0]),
        .data_line0(dl[0][0]), .data_line1(dl[0][1]), .data_line2(dl[0][2]),
        .vbit_o(vbo[0]), .frame_done(fdo[0])
    );

    conv_window_buffer dutL (
        .clk(clk), .rst(tbR[1]), .vbit_i(tbV[1]), .pixel_i(tbP[1]),
        .data_line0(dl[1][0]), .data_line1(dl[1][1]), .data_line2(dl[1][2]),
        .vbit_o(vbo[1]), .frame_done(fdo[1])
    );

    int total = 0;
    int bad = 0;
    int winCnt = 0;
    int fdCnt = 0;

    int imgW [2] = '{4, 28};
    int imgH [2] = '{4, 28};
    int mr [2] = '{0, 0};
    int mc [2] = '{0, 0};
    logic [7:0]  img [2][28][28];
    logic [23:0] eL [2][3];

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply current inputs, advance the model, compare every output of both instances.
    task automatic tick();
        logic ev, efd;
        int r, c;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            ev = 1'b0;
            efd = 1'b0;
            if (tbR[d]) begin
                mr[d] = 0;
                mc[d] = 0;
                for (int k = 0; k < 3; k++) eL[d][k] = '0;
            end else if (tbV[d]) begin
                r = mr[d];
                c = mc[d];
                img[d][r][c] = tbP[d];
                ev = r >= 2 && c >= 2;
                efd = ev && r == imgH[d] - 1 && c == imgW[d] - 1;
                if (ev)
                    for (int k = 0; k < 3; k++)
                        eL[d][k] = {img[d][r-2+k][c], img[d][r-2+k][c-1], img[d][r-2+k][c-2]};
                mc[d] = c + 1;
                if (mc[d] == imgW[d]) begin
                    mc[d] = 0;
                    mr[d] = (r + 1 == imgH[d]) ? 0 : r + 1;
                end
            end
            check($sformatf("vbit_o[%0d]", d), {23'd0, vbo[d]}, {23'd0, ev});
            check($sformatf("frame_done[%0d]", d), {23'd0, fdo[d]}, {23'd0, efd});
            for (int k = 0; k < 3; k++)
                check($sformatf("data_line%0d[%0d]", k, d), dl[d][k], eL[d][k]);
        end
        if (vbo[1]) winCnt++;
        if (fdo[1]) fdCnt++;
    endtask

    task automatic pix(input int d, input logic v, input logic [7:0] p);
        tbV[d] = v;
        tbP[d] = p;
        tick();
        tbV[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            tbR[d] = 1'b1;
            tbV[d] = 1'b0;
            tbP[d] = '0;
            for (int k = 0; k < 3; k++) eL[d][k] = '0;
        end
        tick();
        tick();
        tbR[0] = 1'b0;
        tbR[1] = 1'b0;

        // idle after reset: everything stays zero
        for (int i = 0; i < 100; i++) tick();

        // small frame, gapless
        for (int i = 0; i < 16; i++) begin
            pix(0, 1'b1, 8'(i));
            if (i == 10) begin
                check("first_l0", dl[0][0], 24'h020100);
                check("first_l1", dl[0][1], 24'h060504);
                check("first_l2", dl[0][2], 24'h0A0908);
            end
            if (i == 15) begin
                check("last_l0", dl[0][0], 24'h070605);
                check("last_l1", dl[0][1], 24'h0B0A09);
                check("last_l2", dl[0][2], 24'h0F0E0D);
                check("last_fd", {23'd0, fdo[0]}, 24'd1);
            end
        end

        // same frame, valid toggling every cycle
        for (int i = 0; i < 16; i++) begin
            pix(0, 1'b1, 8'(i));
            pix(0, 1'b0, 8'hAA);
        end

        // reset after 10 pixels, then fresh frame
        for (int i = 0; i < 10; i++) pix(0, 1'b1, 8'(i + 16));
        tbR[0] = 1'b1;
        tbV[0] = 1'b1;
        tbP[0] = 8'h55;
        tick();
        check("rst_l2", dl[0][2], 24'h0);
        tick();
        tbR[0] = 1'b0;
        tbV[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(0, 1'b1, 8'(i));
            if (i == 10) check("rst_first_l0", dl[0][0], 24'h020100);
        end

        // random gaps and pixels; signed-range bytes at (2,2)
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 16; i++) begin
                logic [7:0] p;
                while ($urandom_range(0, 2) == 0) pix(0, 1'b0, 8'($urandom));
                p = (f == 0 && i == 10) ? 8'h80 : (f == 1 && i == 10) ? 8'hFF : 8'($urandom);
                pix(0, 1'b1, p);
                if (f < 2 && i == 10) check("signed_pix", {16'd0, dl[0][2][23:16]}, {16'd0, p});
            end

        // default size: two back-to-back patterned frames
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 28; r++)
                for (int c = 0; c < 28; c++)
                    pix(1, 1'b1, 8'((r * 28 + c) & 8'hFF));
        check("win_count", 24'(winCnt), 24'd1352);
        check("fd_count", 24'(fdCnt), 24'd2);

        // default size: random pixels with random gaps
        for (int i = 0; i < 784; i++) begin
            if ($urandom_range(0, 3) == 0) pix(1, 1'b0, 8'($urandom));
            pix(1, 1'b1, 8'($urandom));
        end
        check("fd_count2", 24'(fdCnt), 24'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Upstream feeder for the 3x3 fixed-point convolution core.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle.
- Stores the two previous image rows and a 3x3 sliding window.
- Emits three 24-bit window rows with a valid bit. Only valid-region windows are emitted (no padding, stride 1), and they drive the core's data_line0/1/2 and vbit_i directly.

Parameters:
- IMG_WIDTH, 28, pixels per row (>=3).
- IMG_HEIGHT, 28, rows per frame (>=3).
- COL_W, 5, column counter width (>= clog2(IMG_WIDTH)).
- ROW_W, 5, row counter width (>= clog2(IMG_HEIGHT)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- vbit_i  in  1  pixel_i valid this cycle.
- pixel_i  in  8  input pixel, fixed-point, passed through bit-exact.
- data_line0  out  24  window row r-2: [7:0]=col c-2, [15:8]=col c-1, [23:16]=col c.
- data_line1  out  24  window row r-1, same byte order.
- data_line2  out  24  window row r (newest), same byte order.
- vbit_o  out  1  window outputs valid (single-cycle qualifier).
- frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - col=0, row=0.
  - window registers, data_line0/1/2, vbit_o and frame_done all cleared to 0.
  - Line-buffer contents need not be cleared: no window is emitted until rows 0..1 are rewritten.
- Accepted pixel (vbit_i=1) at position (row, col):
  - Line buffer B1 holds row-1 and B0 holds row-2, both indexed by col.
  - Same edge: B0[col] <= B1[col]; B1[col] <= pixel_i.
  - Each window row shifts left by one byte. New bytes, in order line0/line1/line2: old B0[col], old B1[col], pixel_i.
  - col increments. At col=IMG_WIDTH-1 it wraps to 0 and row increments. At row=IMG_HEIGHT-1, col=IMG_WIDTH-1 both wrap to 0 and the next pixel starts a new frame.
- Output timing:
  - Outputs are registered; latency is 1 cycle.
  - vbit_o=1 on the cycle after a pixel accepted with row>=2 and col>=2.
  - data_line0/1/2 on that cycle hold the window whose bottom-right pixel is the accepted one.
- Per frame:
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are emitted.
  - No window straddles a row boundary; col<2 windows are suppressed even though the window registers contain previous-row bytes.
- vbit_i=0: counters, buffers and window registers hold. vbit_o=0 next cycle; data_line outputs hold their last value.
- Gaps: arbitrary gaps between valid pixels, including mid-row and between frames, must not change the output sequence versus a gapless stream.
- frame_done: asserted together with vbit_o for the window at (IMG_HEIGHT-1, IMG_WIDTH-1), else 0.
- Reset mid-frame: counters return to (0,0). The next accepted pixel is treated as frame pixel (0,0); no stale window is emitted for the first two rows.
- Back-to-back frames: the first window of frame N+1 appears only after its row 2, col 2. Rows of frame N in the buffers are never emitted as frame N+1 windows.
- No backpressure: the downstream convolution core always accepts.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0x00..0x0F gapless -> 4 windows.
  - First: data_line0=24'h020100, data_line1=24'h060504, data_line2=24'h0A0908, one cycle after pixel 0x0A.
  - Last: 24'h070605 / 24'h0B0A09 / 24'h0F0E0D, with frame_done=1.
- Same stream with vbit_i toggling 1,0,1,0 -> identical 4 windows; vbit_o never high on consecutive cycles; data_line outputs stable between windows.
- Defaults 28x28, two back-to-back frames with pixel=(row*28+col)&0xFF -> 676 windows per frame; exactly 2 frame_done pulses; first window of frame 2 has no frame-1 bytes.
- rst asserted after 10 pixels of a 4x4 frame, then a fresh 0x00..0x0F stream -> outputs 0 during reset; output identical to the first scenario.
- Signed-range pixels 0x80 and 0xFF at (2,2) -> appear unchanged in data_line2[23:16]; no sign extension or alteration.
- vbit_i held 0 for 100 cycles after reset -> vbit_o=0, frame_done=0, data_line0/1/2=0 throughout.
